// File: rtl/fc_cpu_bus_master.sv
// Famicom CPU-side bus initiator: one free-running M2 period per host command, plus power-up m2_rst.
// Define FCBUS_RDSUM_EN to add the rd_sum read-data accumulator (rd_sum / rd_sum_clr ports).
module fc_cpu_bus_master #(
  parameter int unsigned M2_LOW_CYC  = 14,
  parameter int unsigned M2_HIGH_CYC = 14,
  parameter int unsigned RST_M2_CYC  = 8
) (
  input  logic        osc50,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        m2_rst,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
`ifdef FCBUS_RDSUM_EN
  ,
  output logic [15:0] rd_sum,
  input  logic        rd_sum_clr
`endif
);

  localparam int unsigned PERIOD = M2_LOW_CYC + M2_HIGH_CYC;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned FALL_W = $clog2(RST_M2_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_HIGH  = CNT_W'(M2_LOW_CYC);
  localparam logic [FALL_W-1:0] FALL_DONE = FALL_W'(RST_M2_CYC);

  typedef enum logic {ST_RST_SEQ, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FALL_W-1:0]   fall_q, fall_d;
  logic                m2_q, m2_d, m2_rst_q, m2_rst_d, romsel_q, romsel_d;
  logic                a15_q, a15_d, rw_q, rw_d, oe_q, oe_d;
  logic [14:0]         addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                rdy_q, rdy_d;
  logic                pend_q, pend_d, pend_rw_q, pend_rw_d;
  logic [15:0]         pend_addr_q, pend_addr_d;
  logic [7:0]          pend_wdata_q, pend_wdata_d;
  logic                rd_act_q, rd_act_d;
  logic                rsp_q, rsp_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                bnd_c, lo1_c, acc_c;

  assign bnd_c = (cnt_q == CNT_LAST);
  assign lo1_c = (cnt_q == '0);
  assign acc_c = cmd_valid & rdy_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = bnd_c ? '0 : cnt_q + CNT_W'(1);
    m2_d         = (cnt_d >= CNT_HIGH);
    fall_d       = fall_q;
    m2_rst_d     = m2_rst_q;
    a15_d        = a15_q;
    rw_d         = rw_q;
    oe_d         = oe_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    pend_d       = pend_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    rd_act_d     = rd_act_q;
    rsp_d        = 1'b0;
    rdata_d      = rdata_q;

    // Power-up sequence: release m2_rst the cycle after the last counted M2 fall
    case (state_q)
      ST_RST_SEQ: begin
        if (fall_q == FALL_DONE) begin
          state_d  = ST_RUN;
          m2_rst_d = 1'b1;
        end else if (bnd_c) begin
          fall_d = fall_q + FALL_W'(1);
        end
      end
      ST_RUN:  m2_rst_d = 1'b1;
      default: state_d = ST_RST_SEQ;
    endcase

    rdy_d = (state_d == ST_RUN) && (cnt_d == CNT_LAST);

    // Last HIGH cycle: latch the next command and sample the read in flight
    if (bnd_c) begin
      pend_d = acc_c;
      if (acc_c) begin
        pend_rw_d    = cmd_rw;
        pend_addr_d  = cmd_addr;
        pend_wdata_d = cmd_wdata;
      end
      if (rd_act_q) begin
        rsp_d   = 1'b1;
        rdata_d = cpu_data_in;
      end
    end

    // Bus changes only after the first LOW cycle, giving one cycle of hold past the M2 fall
    if (lo1_c) begin
      rd_act_d = pend_q & pend_rw_q;
      if (pend_q) begin
        rw_d   = pend_rw_q;
        oe_d   = ~pend_rw_q;
        a15_d  = pend_addr_q[15];
        addr_d = pend_addr_q[14:0];
        if (!pend_rw_q) dout_d = pend_wdata_q;
      end else begin
        rw_d  = 1'b1;
        oe_d  = 1'b0;
        a15_d = 1'b0;
      end
    end

    romsel_d = ~(a15_d & m2_d);
  end

  always_ff @(posedge osc50) begin
    if (rst) begin
      state_q      <= ST_RST_SEQ;
      cnt_q        <= '0;
      fall_q       <= '0;
      m2_q         <= 1'b0;
      m2_rst_q     <= 1'b0;
      romsel_q     <= 1'b1;
      a15_q        <= 1'b0;
      rw_q         <= 1'b1;
      oe_q         <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      rdy_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_rw_q    <= 1'b1;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rd_act_q     <= 1'b0;
      rsp_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fall_q       <= fall_d;
      m2_q         <= m2_d;
      m2_rst_q     <= m2_rst_d;
      romsel_q     <= romsel_d;
      a15_q        <= a15_d;
      rw_q         <= rw_d;
      oe_q         <= oe_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      rdy_q        <= rdy_d;
      pend_q       <= pend_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      rd_act_q     <= rd_act_d;
      rsp_q        <= rsp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cmd_ready    = rdy_q;
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign m2           = m2_q;
  assign m2_rst       = m2_rst_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;

`ifdef FCBUS_RDSUM_EN
  logic [15:0] sum_q, sum_d;

  // Running sum of returned read bytes; clear takes priority over a same-cycle add
  always_comb begin
    sum_d = sum_q;
    if (rd_sum_clr)  sum_d = '0;
    else if (rsp_q)  sum_d = sum_q + 16'(rdata_q);
  end

  always_ff @(posedge osc50) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign rd_sum = sum_q;
`endif

endmodule

// File: tb/tb_fc_cpu_bus_master.sv
// Self-checking bench for fc_cpu_bus_master: reset sequence, single/burst commands, mid-op reset.
// Read responses are checked against a scoreboard queue filled when each read is accepted.
module tb_fc_cpu_bus_master;

  localparam int LOW   = 14;
  localparam int PER   = 28;
  localparam int LAST  = PER - 1;
  localparam int RST_N = 8;

  logic        osc50 = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  cpu_data_in = '0;
  logic        cmd_ready, rsp_valid, m2, m2_rst, romsel, cpu_rw, cpu_data_oe;
  logic [7:0]  rsp_rdata, cpu_data_out;
  logic [14:0] cpu_addr;
`ifdef FCBUS_RDSUM_EN
  logic [15:0] rd_sum;
  logic        rd_sum_clr = 1'b0;
`endif

  fc_cpu_bus_master dut (
    .osc50(osc50), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .m2_rst(m2_rst), .romsel(romsel), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in)
`ifdef FCBUS_RDSUM_EN
    , .rd_sum(rd_sum), .rd_sum_clr(rd_sum_clr)
`endif
  );

  always #5 osc50 = ~osc50;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   ph = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  logic        bw_rw[4];
  logic [15:0] bw_a[4];
  logic [7:0]  bw_d[4];
  int          bw_b[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference M2 phase: LOW phase first after reset, wrapping every PER cycles
  always @(posedge osc50) begin
    cyc <= cyc + 1;
    if (rst) ph <= 0;
    else     ph <= (ph == LAST) ? 0 : ph + 1;
  end

  always @(negedge osc50) begin
    if (mon_en) begin
      chk("m2_phase", 32'(m2), 32'(ph >= LOW));
      chk("rdy_bnd", 32'(cmd_ready && (ph != LAST)), 0);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_spur", 32'(rsp_valid), 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_data", 32'(rsp_rdata), 32'(mon_e.d));
          chk("rsp_lat", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    int n = 0;
    do begin
      @(negedge osc50);
      n++;
    end while (cyc < t && n < 4 * PER);
  endtask

  task automatic chk_rst_seq();
    int falls = 0, f1 = 0, f2 = 0, lastf = 0, rise, n = 0;
    logic pm2;
    pm2 = m2;
    while (m2_rst !== 1'b1 && n < 40 * PER) begin
      @(negedge osc50);
      n++;
      if (pm2 === 1'b1 && m2 === 1'b0) begin
        falls++;
        lastf = cyc;
        if (falls == 1) f1 = cyc;
        if (falls == 2) f2 = cyc;
      end
      pm2 = m2;
    end
    rise = cyc;
    chk("rst_done", 32'(m2_rst), 1);
    chk("rst_falls", falls, RST_N);
    chk("rst_lag", rise - lastf, 1);
    chk("m2_period", f2 - f1, PER);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2 * PER) begin
      @(negedge osc50);
      n++;
    end
    chk("rdy_first", 32'(cmd_ready), 1);
    chk("rdy_lat", cyc - rise, 26);
  endtask

  task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] d, output int b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 2 * PER) begin
      @(negedge osc50);
      n++;
    end
    chk("acc_rdy", 32'(cmd_ready), 1);
    b = cyc;
    @(posedge osc50);
    #1;
    cmd_valid = 1'b0;
    if (rw) begin
      cpu_data_in = d;
      sbq.push_back('{d: d, due: b + PER + 1});
    end
  endtask

  // One command period preceded and followed by idle periods, starting in LOW cycle 1
  task automatic sweep(input logic rw, input logic [14:0] a, input logic [7:0] d, input int lows);
    int   nlo = 0;
    logic oe_e;
    oe_e = ~rw;
    for (int i = 1; i <= 30; i++) begin
      @(negedge osc50);
      if (romsel === 1'b0) begin
        nlo++;
        chk("romsel_m2", 32'(m2), 1);
      end
      if (i == 1)  chk("hold_pre", 32'({cpu_rw, cpu_data_oe}), 32'h2);
      if (i == 30) chk("idle_post", 32'({cpu_rw, cpu_data_oe}), 32'h2);
      if (i >= 2 && i <= 29) begin
        chk("bus", 32'({cpu_rw, cpu_addr, cpu_data_oe}), 32'({rw, a, oe_e}));
        if (!rw) chk("wdata", 32'(cpu_data_out), 32'(d));
      end
      if (i == 29) chk("hold_m2", 32'(m2), 0);
    end
    chk("romsel_lows", nlo, lows);
  endtask

  task automatic burst(input int n);
    int   w;
    logic rs_e;
    cmd_valid = 1'b1;
    cmd_rw    = bw_rw[0];
    cmd_addr  = bw_a[0];
    cmd_wdata = bw_d[0];
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (cmd_ready !== 1'b1 && w < 2 * PER) begin
        @(negedge osc50);
        w++;
      end
      chk("b_rdy", 32'(cmd_ready), 1);
      bw_b[k] = cyc;
      if (k > 0) chk("b_gap", bw_b[k] - bw_b[k-1], PER);
      @(posedge osc50);
      #1;
      if (k + 1 < n) begin
        cmd_rw    = bw_rw[k+1];
        cmd_addr  = bw_a[k+1];
        cmd_wdata = bw_d[k+1];
      end else begin
        cmd_valid = 1'b0;
      end
      if (bw_rw[k]) begin
        cpu_data_in = bw_d[k];
        sbq.push_back('{d: bw_d[k], due: bw_b[k] + PER + 1});
      end
      wait_cyc(bw_b[k] + 15);
      if (!bw_rw[k]) begin
        rs_e = ~bw_a[k][15];
        chk("b_bus", 32'({cpu_rw, cpu_addr, cpu_data_oe, cpu_data_out}),
            32'({1'b0, bw_a[k][14:0], 1'b1, bw_d[k]}));
        chk("b_romsel", 32'(romsel), 32'(rs_e));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (3) @(negedge osc50);
    chk("rst_vals", 32'({m2, m2_rst, romsel, cpu_rw, cpu_data_oe, cmd_ready, rsp_valid}), 32'b0011000);
    chk("rst_bus", 32'({cpu_addr, cpu_data_out, rsp_rdata}), 0);
`ifdef FCBUS_RDSUM_EN
    chk("rst_sum", 32'(rd_sum), 0);
`endif
    mon_en = 1'b1;
    rst = 1'b0;
    chk_rst_seq();

    // Single write to ROM space, then single read outside ROM space
    issue(1'b0, 16'h8000, 8'hA5, b);
    sweep(1'b0, 15'h0000, 8'hA5, 14);
    issue(1'b1, 16'h5001, 8'h3C, b);
    sweep(1'b1, 15'h5001, 8'h00, 0);

    // cmd_valid held across three writes
    bw_rw[0] = 1'b0; bw_a[0] = 16'h8000; bw_d[0] = 8'h11;
    bw_rw[1] = 1'b0; bw_a[1] = 16'h8001; bw_d[1] = 8'h22;
    bw_rw[2] = 1'b0; bw_a[2] = 16'h5000; bw_d[2] = 8'h33;
    burst(3);

    // Reset during the HIGH phase of a write
    issue(1'b0, 16'h8002, 8'h77, b);
    wait_cyc(b + 20);
    chk("rst_pre", 32'({cpu_rw, romsel, cpu_data_oe}), 32'b001);
    rst = 1'b1;
    @(negedge osc50);
    chk("rst_mid", 32'({m2, cpu_rw, cpu_data_oe, m2_rst, rsp_valid, romsel}), 32'b010001);
    rst = 1'b0;
    chk_rst_seq();

    // Reset during a read: the response must be dropped
    issue(1'b1, 16'h8123, 8'h99, b);
    wait_cyc(b + 20);
    sbq.delete();
    rst = 1'b1;
    @(negedge osc50);
    chk("rst_rd", 32'({m2, cpu_rw, rsp_valid}), 32'b010);
    rst = 1'b0;
    chk_rst_seq();

    // Back-to-back reads returning FF, FF, 02
    bw_rw[0] = 1'b1; bw_a[0] = 16'h6000; bw_d[0] = 8'hFF;
    bw_rw[1] = 1'b1; bw_a[1] = 16'h6001; bw_d[1] = 8'hFF;
    bw_rw[2] = 1'b1; bw_a[2] = 16'h6002; bw_d[2] = 8'h02;
    burst(3);
    wait_cyc(bw_b[2] + PER + 2);
`ifdef FCBUS_RDSUM_EN
    chk("sum_3rd", 32'(rd_sum), 32'h0200);
`endif
    issue(1'b1, 16'h6003, 8'h11, b);
    wait_cyc(b + PER + 1);
    chk("rsp4_valid", 32'(rsp_valid), 1);
`ifdef FCBUS_RDSUM_EN
    rd_sum_clr = 1'b1;
    @(negedge osc50);
    rd_sum_clr = 1'b0;
    chk("sum_clr", 32'(rd_sum), 0);
`else
    @(negedge osc50);
`endif

    repeat (4) @(negedge osc50);
    chk("sb_empty", sbq.size(), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
